// File: rtl/pc_pkg.sv
// Package: pc_pkg
// Shared constants for the program-counter sequencer: the opcode values
// decoded from pc_scr and the two-state FSM encoding (RUN / HALTED).
package pc_pkg;

    localparam logic [6:0] OP_HALT   = 7'h7F;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

endpackage

// File: rtl/return_address_stack.sv
// Module: return_address_stack
// Circular return-address stack with a top pointer and an entry count.
// A push while full overwrites the oldest entry, keeps count at RAS_DEPTH
// and sets the sticky overflow flag. A simultaneous push and pop replaces
// the top entry in place (count unchanged).
// Ports:
//   clk, rst     clock, synchronous active-low reset (clears count/overflow)
//   push, pop    stack operations for this cycle
//   push_data    value written on push
//   top          current top entry (valid when !empty)
//   empty, full  occupancy status
//   overflow     sticky: a push happened while full
module return_address_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_idx;

    assign top   = mem[ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(RAS_DEPTH));

    // Push after pop lands on the slot the pop just vacated, i.e. the current top.
    assign wr_idx = pop ? ptr : ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (push && pop) begin
            ptr <= ptr;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (pop) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    // Entry storage carries no reset; only count decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Module: pc_sequencer
// Program-counter unit for the fetch stage: PC register, next-PC selection,
// RUN/HALTED FSM and a return-address stack for call/return prediction.
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   pc_scr           opcode (HALT, JAL, JALR, BRANCH, else sequential)
//   condition        branch taken for BRANCH
//   jump_add         redirect target for JAL/JALR/BRANCH
//   is_call, is_ret  JAL/JALR link push / JALR return prediction
//   stall, trap_req  hold PC / redirect to TRAP_VECTOR
//   current_ins_add  registered fetch address
//   pc_plus4         current_ins_add + 4 (combinational, wraps)
//   halted           registered HALTED state flag
//   misalign         one-cycle pulse: last loaded target had bits[1:0]!=0
//   ras_overflow     sticky: a call push happened while the RAS was full
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       pc_scr,
    input  logic             condition,
    input  logic [WIDTH-1:0] jump_add,
    input  logic             is_call,
    input  logic             is_ret,
    input  logic             stall,
    input  logic             trap_req,
    output logic [WIDTH-1:0] current_ins_add,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             halted,
    output logic             misalign,
    output logic             ras_overflow
);

    function automatic logic [WIDTH-1:0] align_word(input logic [WIDTH-1:0] a);
        return {a[WIDTH-1:2], 2'b00};
    endfunction

    logic [0:0]       state, next_state;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] target;
    logic             redirect;
    logic             next_misalign;
    logic             push, pop;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    // Full status is consumed inside the stack only.
    logic             ras_full_unused;

    assign pc_plus4 = current_ins_add + WIDTH'(4);
    assign halted   = (state == HALTED);

    return_address_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full_unused),
        .overflow  (ras_overflow)
    );

    always_comb begin
        next_state    = state;
        next_pc       = current_ins_add;
        next_misalign = 1'b0;
        target        = '0;
        redirect      = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        // HALTED and stall both freeze everything; misalign falls back to 0.
        if (state == RUN && !stall) begin
            if (trap_req) begin
                target   = TRAP_VECTOR;
                redirect = 1'b1;
            end else begin
                case (pc_scr)
                    OP_HALT: next_state = HALTED;
                    OP_JAL: begin
                        target   = jump_add;
                        redirect = 1'b1;
                        push     = is_call;
                    end
                    OP_JALR: begin
                        if (is_ret && !ras_empty) begin
                            target = ras_top;
                            pop    = 1'b1;
                        end else begin
                            target = jump_add & ~WIDTH'(1);
                        end
                        redirect = 1'b1;
                        push     = is_call;
                    end
                    OP_BRANCH: begin
                        if (condition) begin
                            target   = jump_add;
                            redirect = 1'b1;
                        end else begin
                            next_pc = pc_plus4;
                        end
                    end
                    default: next_pc = pc_plus4;
                endcase
            end
            if (redirect) begin
                next_pc       = align_word(target);
                next_misalign = |target[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= RUN;
            current_ins_add <= RESET_VECTOR;
            misalign        <= 1'b0;
        end else begin
            state           <= next_state;
            current_ins_add <= next_pc;
            misalign        <= next_misalign;
        end
    end

endmodule
